// File: rtl/dram_arbiter.sv
// Round-robin arbiter that issues one core access per cycle to a single-port synchronous DRAM
// and returns read data to the requesting core with a one-hot valid.
module dram_arbiter #(
   parameter int unsigned N_CORES = 4,
   parameter int unsigned ADDR_W  = 16,
   parameter int unsigned DATA_W  = 8,
   parameter int unsigned RD_LAT  = 1
) (
   input  logic                        i_clk,
   input  logic                        i_rst_n,
   input  logic [N_CORES-1:0]          i_req,
   input  logic [N_CORES-1:0]          i_we,
   input  logic [N_CORES*ADDR_W-1:0]   i_addr,
   input  logic [N_CORES*DATA_W-1:0]   i_wdata,
   output logic [N_CORES-1:0]          o_gnt,
   output logic [N_CORES-1:0]          o_rvalid,
   output logic [DATA_W-1:0]           o_rdata,
   output logic [ADDR_W-1:0]           o_mem_addr,
   output logic [DATA_W-1:0]           o_mem_data,
   output logic                        o_mem_rden,
   output logic                        o_mem_wren,
   input  logic [DATA_W-1:0]           i_mem_q,
   output logic                        o_busy
);

   localparam int unsigned PTR_W = $clog2(N_CORES);

   logic [ADDR_W-1:0]  w_addr_a  [N_CORES];
   logic [DATA_W-1:0]  w_wdata_a [N_CORES];
   logic [N_CORES-1:0] w_elig;
   logic [N_CORES-1:0] w_win;
   logic [N_CORES-1:0] w_tag_any;
   logic [PTR_W-1:0]   w_win_idx;
   logic               w_found;
   logic               w_sel_we;
   logic [ADDR_W-1:0]  w_sel_addr;
   logic [DATA_W-1:0]  w_sel_wdata;
   logic [31:0]        w_idx;

   logic [N_CORES-1:0] r_gnt;
   logic [N_CORES-1:0] r_tag [RD_LAT];
   logic [PTR_W-1:0]   r_ptr;
   logic [ADDR_W-1:0]  r_mem_addr;
   logic [DATA_W-1:0]  r_mem_data;
   logic               r_mem_rden;
   logic               r_mem_wren;

   genvar gk;
   generate
      for (gk = 0; gk < N_CORES; gk++) begin : g_unpack
         assign w_addr_a[gk]  = i_addr[gk*ADDR_W +: ADDR_W];
         assign w_wdata_a[gk] = i_wdata[gk*DATA_W +: DATA_W];
      end
   endgenerate

   // The core shown a grant this cycle is masked, so its still-held request is not granted twice.
   always_comb begin : p_arb
      w_elig    = i_req & ~r_gnt;
      w_found   = 1'b0;
      w_win_idx = r_ptr;
      w_idx     = 32'd0;
      for (int unsigned i = 1; i <= N_CORES; i++) begin
         w_idx = (32'(r_ptr) + 32'(i)) % 32'(N_CORES);
         if (!w_found && w_elig[PTR_W'(w_idx)]) begin
            w_found   = 1'b1;
            w_win_idx = PTR_W'(w_idx);
         end
      end
      w_win = w_found ? (N_CORES'(1) << w_win_idx) : '0;
   end

   assign w_sel_we    = i_we[w_win_idx];
   assign w_sel_addr  = w_addr_a[w_win_idx];
   assign w_sel_wdata = w_wdata_a[w_win_idx];

   always_comb begin : p_busy
      w_tag_any = '0;
      for (int unsigned i = 0; i < RD_LAT; i++) begin
         w_tag_any = w_tag_any | r_tag[i];
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin : p_seq
      if (!i_rst_n) begin
         r_gnt      <= '0;
         r_ptr      <= PTR_W'(N_CORES - 1);
         r_mem_addr <= '0;
         r_mem_data <= '0;
         r_mem_rden <= 1'b0;
         r_mem_wren <= 1'b0;
         for (int unsigned i = 0; i < RD_LAT; i++) begin
            r_tag[i] <= '0;
         end
      end else begin
         r_gnt      <= w_win;
         r_mem_rden <= w_found & ~w_sel_we;
         r_mem_wren <= w_found & w_sel_we;
         if (w_found) begin
            r_ptr      <= w_win_idx;
            r_mem_addr <= w_sel_addr;
            if (w_sel_we) begin
               r_mem_data <= w_sel_wdata;
            end
         end
         // Read tags travel alongside the DRAM latency; the last stage is the one-hot rvalid.
         r_tag[0] <= r_mem_rden ? r_gnt : '0;
         for (int unsigned i = 1; i < RD_LAT; i++) begin
            r_tag[i] <= r_tag[i-1];
         end
      end
   end

   assign o_gnt      = r_gnt;
   assign o_rvalid   = r_tag[RD_LAT-1];
   assign o_rdata    = i_mem_q;
   assign o_mem_addr = r_mem_addr;
   assign o_mem_data = r_mem_data;
   assign o_mem_rden = r_mem_rden;
   assign o_mem_wren = r_mem_wren;
   assign o_busy     = (|i_req) | (|w_tag_any);

endmodule

// File: tb/tb_dram_arbiter.sv
// Bench for dram_arbiter: directed vector table, hand-written corner sequences, and random
// traffic checked against a transaction-level model of grants, memory contents and read returns.
module tb_dram_arbiter;

   localparam int RD_LAT = 1;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [3:0]  req, we;
   logic [63:0] addr;
   logic [31:0] wdata;
   logic [3:0]  o_gnt, o_rvalid;
   logic [7:0]  o_rdata, o_mem_data, i_mem_q;
   logic [15:0] o_mem_addr;
   logic        o_mem_rden, o_mem_wren, o_busy;

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;

   always #5 clk = ~clk;

   dram_arbiter #(.N_CORES(4), .ADDR_W(16), .DATA_W(8), .RD_LAT(RD_LAT)) dut (
      .i_clk(clk), .i_rst_n(rst_n), .i_req(req), .i_we(we), .i_addr(addr), .i_wdata(wdata),
      .o_gnt(o_gnt), .o_rvalid(o_rvalid), .o_rdata(o_rdata), .o_mem_addr(o_mem_addr),
      .o_mem_data(o_mem_data), .o_mem_rden(o_mem_rden), .o_mem_wren(o_mem_wren),
      .i_mem_q(i_mem_q), .o_busy(o_busy)
   );

   // DRAM macro model: synchronous single port, read data RD_LAT cycles after sampling.
   logic [7:0] dram [65536];
   logic [7:0] q_pipe [RD_LAT];
   always @(posedge clk) begin
      if (o_mem_wren) dram[o_mem_addr] = o_mem_data;
      if (o_mem_rden) q_pipe[0] <= dram[o_mem_addr];
      for (int i = 1; i < RD_LAT; i++) q_pipe[i] <= q_pipe[i-1];
   end
   assign i_mem_q = q_pipe[RD_LAT-1];

   // Reference model: last winner, core shown a grant, predicted commands, pending reads.
   typedef struct { int g; int core; logic [7:0] d; } rd_t;
   rd_t        rq[$];
   logic [7:0] shadow [65536];
   int         m_ptr, m_prev;
   logic [3:0] e_gnt;
   logic       e_rden, e_wren;
   logic [15:0] e_addr;
   logic [7:0]  e_data;

   task automatic model_reset();
      m_ptr = 3; m_prev = -1; e_gnt = 0; e_rden = 0; e_wren = 0; e_addr = 0; e_data = 0;
      rq.delete();
   endtask

   task automatic model_edge();
      int win;
      win = -1;
      for (int i = 1; i <= 4; i++) begin
         int k;
         k = (m_ptr + i) % 4;
         if (win < 0 && req[k] && k != m_prev) win = k;
      end
      m_prev = win; e_gnt = 0; e_rden = 0; e_wren = 0;
      if (win >= 0) begin
         m_ptr = win;
         e_gnt = 4'(1 << win);
         e_addr = addr[win*16 +: 16];
         if (we[win]) begin
            e_wren = 1; e_data = wdata[win*8 +: 8];
            shadow[e_addr] = e_data;
         end else begin
            e_rden = 1;
            rq.push_back('{cyc + 1, win, shadow[e_addr]});
         end
      end
      cyc++;
   endtask

   task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      model_edge();
      #1;
   endtask

   task automatic do_reset();
      req = 0; we = 0; addr = 0; wdata = 0;
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      model_reset();
   endtask

   typedef struct {
      bit rst; logic [3:0] req, we; logic [63:0] addr; logic [31:0] wd;
      logic [3:0] gnt; bit rden, wren; logic [15:0] maddr; logic [7:0] mdata;
      logic [3:0] rvalid; logic [7:0] rdata; bit busy;
   } vec_t;

   function automatic vec_t mk(bit rst, logic [3:0] rq_, logic [3:0] we_, logic [63:0] a,
                               logic [31:0] wd, logic [3:0] g, bit rd, bit wr, logic [15:0] ma,
                               logic [7:0] md, logic [3:0] rv, logic [7:0] rdat, bit bz);
      vec_t v;
      v.rst = rst; v.req = rq_; v.we = we_; v.addr = a; v.wd = wd; v.gnt = g; v.rden = rd;
      v.wren = wr; v.maddr = ma; v.mdata = md; v.rvalid = rv; v.rdata = rdat; v.busy = bz;
      return v;
   endfunction

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      vec_t vt[$];
      logic [63:0] a_sr, a_sim, a_mix;
      logic [31:0] wd_mix;

      // Reset state, observed while reset is held.
      req = 0; we = 0; addr = 0; wdata = 0; rst_n = 1'b0;
      model_reset();
      #3;
      chk("rst.gnt", o_gnt, 0);     chk("rst.rvalid", o_rvalid, 0);
      chk("rst.rden", o_mem_rden, 0); chk("rst.wren", o_mem_wren, 0);
      chk("rst.addr", o_mem_addr, 0); chk("rst.data", o_mem_data, 0);
      chk("rst.busy", o_busy, 0);

      dram[16'h0010] = 8'h5A;
      for (int i = 0; i < 4; i++) dram[16'h0100 + i] = 8'(8'h11 + i);

      a_sr   = {16'h0000, 16'h0000, 16'h0000, 16'h0010};
      a_sim  = {16'h0103, 16'h0102, 16'h0101, 16'h0100};
      a_mix  = {16'h0200, 16'h0000, 16'h0200, 16'h0000};
      wd_mix = {8'h00, 8'h00, 8'h77, 8'h00};
      // single read
      vt.push_back(mk(1, 4'b0001, 0, a_sr, 0, 4'b0001, 1, 0, 16'h0010, 0, 4'b0000, 0, 1));
      vt.push_back(mk(0, 4'b0000, 0, a_sr, 0, 4'b0000, 0, 0, 16'h0010, 0, 4'b0001, 8'h5A, 1));
      vt.push_back(mk(0, 4'b0000, 0, a_sr, 0, 4'b0000, 0, 0, 16'h0010, 0, 4'b0000, 0, 0));
      // simultaneous reads
      vt.push_back(mk(1, 4'b1111, 0, a_sim, 0, 4'b0001, 1, 0, 16'h0100, 0, 4'b0000, 0, 1));
      vt.push_back(mk(0, 4'b1110, 0, a_sim, 0, 4'b0010, 1, 0, 16'h0101, 0, 4'b0001, 8'h11, 1));
      vt.push_back(mk(0, 4'b1100, 0, a_sim, 0, 4'b0100, 1, 0, 16'h0102, 0, 4'b0010, 8'h12, 1));
      vt.push_back(mk(0, 4'b1000, 0, a_sim, 0, 4'b1000, 1, 0, 16'h0103, 0, 4'b0100, 8'h13, 1));
      vt.push_back(mk(0, 4'b0000, 0, a_sim, 0, 4'b0000, 0, 0, 16'h0103, 0, 4'b1000, 8'h14, 1));
      vt.push_back(mk(0, 4'b0000, 0, a_sim, 0, 4'b0000, 0, 0, 16'h0103, 0, 4'b0000, 0, 0));
      // write then read of the same address
      vt.push_back(mk(0, 4'b1010, 4'b0010, a_mix, wd_mix, 4'b0010, 0, 1, 16'h0200, 8'h77, 4'b0000, 0, 1));
      vt.push_back(mk(0, 4'b1000, 4'b0010, a_mix, wd_mix, 4'b1000, 1, 0, 16'h0200, 8'h77, 4'b0000, 0, 1));
      vt.push_back(mk(0, 4'b0000, 4'b0010, a_mix, wd_mix, 4'b0000, 0, 0, 16'h0200, 8'h77, 4'b1000, 8'h77, 1));
      vt.push_back(mk(0, 4'b0000, 4'b0010, a_mix, wd_mix, 4'b0000, 0, 0, 16'h0200, 8'h77, 4'b0000, 0, 0));

      foreach (vt[r]) begin
         if (vt[r].rst) do_reset();
         req = vt[r].req; we = vt[r].we; addr = vt[r].addr; wdata = vt[r].wd;
         tick();
         chk($sformatf("row%0d.gnt", r), o_gnt, vt[r].gnt);
         chk($sformatf("row%0d.rden", r), o_mem_rden, vt[r].rden);
         chk($sformatf("row%0d.wren", r), o_mem_wren, vt[r].wren);
         chk($sformatf("row%0d.maddr", r), o_mem_addr, vt[r].maddr);
         chk($sformatf("row%0d.mdata", r), o_mem_data, vt[r].mdata);
         chk($sformatf("row%0d.rvalid", r), o_rvalid, vt[r].rvalid);
         chk($sformatf("row%0d.busy", r), o_busy, vt[r].busy);
         if (vt[r].rvalid != 0) chk($sformatf("row%0d.rdata", r), o_rdata, vt[r].rdata);
      end

      // Single-core streaming: a held request is granted every other cycle.
      do_reset();
      req = 4'b0100; addr = {16'h0, 16'h0010, 16'h0, 16'h0};
      for (int i = 0; i < 8; i++) begin
         tick();
         chk($sformatf("stream%0d.gnt", i), o_gnt, (i % 2 == 0) ? 4'b0100 : 4'b0000);
         chk($sformatf("stream%0d.rvalid", i), o_rvalid, (i % 2 == 1) ? 4'b0100 : 4'b0000);
      end
      req = 0; tick(); tick();

      // Two writers contend: grants alternate, a write issues every cycle, no read returns.
      do_reset();
      req = 4'b0011; we = 4'b0011;
      addr = {16'h0, 16'h0, 16'h0021, 16'h0020}; wdata = {8'h0, 8'h0, 8'hB1, 8'hA0};
      for (int i = 0; i < 8; i++) begin
         tick();
         chk($sformatf("fair%0d.gnt", i), o_gnt, (i % 2 == 0) ? 4'b0001 : 4'b0010);
         chk($sformatf("fair%0d.wren", i), o_mem_wren, 1);
         chk($sformatf("fair%0d.rvalid", i), o_rvalid, 0);
      end
      req = 0; tick(); tick();
      chk("fair.dram20", dram[16'h0020], 8'hA0);
      chk("fair.dram21", dram[16'h0021], 8'hB1);

      // Reset asserted in the cycle a read is granted.
      do_reset();
      req = 4'b0001; addr = {16'h0, 16'h0, 16'h0, 16'h0010};
      tick();
      chk("midrst.pre_gnt", o_gnt, 4'b0001);
      rst_n = 1'b0; req = 0;
      #1;
      chk("midrst.gnt", o_gnt, 0);       chk("midrst.rden", o_mem_rden, 0);
      chk("midrst.addr", o_mem_addr, 0); chk("midrst.busy", o_busy, 0);
      #1 rst_n = 1'b1;
      model_reset();
      tick();
      chk("midrst.no_rvalid", o_rvalid, 0);
      req = 4'b1001; addr = {16'h0030, 16'h0, 16'h0, 16'h0010};
      tick();
      chk("midrst.first_gnt", o_gnt, 4'b0001);
      req = 4'b1000; tick();
      req = 0; tick(); tick();

      // Random traffic against the model.
      do_reset();
      for (int i = 0; i < 8; i++) begin
         logic [7:0] v;
         v = 8'($urandom);
         dram[16'h0300 + i] = v;
         shadow[16'h0300 + i] = v;
      end
      for (int n = 0; n < 1500; n++) begin
         logic [3:0] rv;
         logic [7:0] rd;
         bit         inflight;
         rd_t        keep[$];
         tick();
         rv = 0; rd = 0; inflight = 0;
         foreach (rq[j]) begin
            if (rq[j].g + RD_LAT == cyc) begin rv = rv | 4'(1 << rq[j].core); rd = rq[j].d; end
            if (rq[j].g < cyc && cyc <= rq[j].g + RD_LAT) inflight = 1;
            if (rq[j].g + RD_LAT > cyc) keep.push_back(rq[j]);
         end
         rq = keep;
         chk("rnd.gnt", o_gnt, e_gnt);
         chk("rnd.rden", o_mem_rden, e_rden);
         chk("rnd.wren", o_mem_wren, e_wren);
         chk("rnd.maddr", o_mem_addr, e_addr);
         chk("rnd.mdata", o_mem_data, e_data);
         chk("rnd.rvalid", o_rvalid, rv);
         chk("rnd.busy", o_busy, (|req) | inflight);
         if (rv != 0) chk("rnd.rdata", o_rdata, rd);
         for (int k = 0; k < 4; k++) begin
            if (e_gnt[k]) req[k] = 1'b0;
            if (!req[k] && $urandom_range(0, 2) == 0) begin
               req[k] = 1'b1;
               we[k] = 1'($urandom_range(0, 1));
               addr[k*16 +: 16] = 16'(16'h0300 + $urandom_range(0, 7));
               wdata[k*8 +: 8] = 8'($urandom);
            end
         end
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
